// File: rtl/fpga_input_debounce.sv
// Two-channel pad synchronizer and debouncer: 2-flop sync, then a per-channel
// qualify FSM that only accepts a level held for STABLE_CYCLES samples.
module fpga_input_debounce #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic in0,
  input  logic in1,
  output logic out0,
  output logic out1,
  output logic rise0,
  output logic rise1,
  output logic fall0,
  output logic fall1
);

  localparam int unsigned NCH = 2;
  // Terminal count: the sample that completes qualification is counted in the same cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam bit DIRECT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_STABLE_LOW,
    ST_QUAL_HIGH,
    ST_STABLE_HIGH,
    ST_QUAL_LOW
  } state_e;

  logic [NCH-1:0] pad;
  logic [NCH-1:0] out_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;

  assign pad = {in1, in0};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    logic             sync_a_q;
    logic             sync_b_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_a_q <= 1'b0;
        sync_b_q <= 1'b0;
        state_q  <= ST_STABLE_LOW;
        cnt_q    <= '0;
        out_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        sync_a_q <= pad[ch];
        sync_b_q <= sync_a_q;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_STABLE_LOW: begin
          cnt_d = '0;
          if (sync_b_q) begin
            if (DIRECT) begin
              state_d = ST_STABLE_HIGH;
            end else begin
              state_d = ST_QUAL_HIGH;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_QUAL_HIGH: begin
          if (!sync_b_q) begin
            state_d = ST_STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE_HIGH: begin
          cnt_d = '0;
          if (!sync_b_q) begin
            if (DIRECT) begin
              state_d = ST_STABLE_LOW;
            end else begin
              state_d = ST_QUAL_LOW;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_QUAL_LOW: begin
          if (sync_b_q) begin
            state_d = ST_STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_STABLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end
      endcase

      // Aborted qualification returns to the current level, so out only moves on acceptance.
      out_d  = (state_d == ST_STABLE_HIGH) || (state_d == ST_QUAL_LOW);
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end

    assign out_vec[ch]  = out_q;
    assign rise_vec[ch] = rise_q;
    assign fall_vec[ch] = fall_q;
  end

  assign out0  = out_vec[0];
  assign out1  = out_vec[1];
  assign rise0 = rise_vec[0];
  assign rise1 = rise_vec[1];
  assign fall0 = fall_vec[0];
  assign fall1 = fall_vec[1];

endmodule

// File: tb/tb_fpga_input_debounce.sv
// Directed, table-driven bench for fpga_input_debounce with STABLE_CYCLES=4.
module tb_fpga_input_debounce;

  localparam int unsigned STABLE = 4;

  // Expected output word layout: {out0, out1, rise0, rise1, fall0, fall1}
  localparam logic [5:0] O00 = 6'b000000;
  localparam logic [5:0] O01 = 6'b010000;
  localparam logic [5:0] O10 = 6'b100000;
  localparam logic [5:0] O11 = 6'b110000;
  localparam logic [5:0] R0  = 6'b001000;
  localparam logic [5:0] R1  = 6'b000100;
  localparam logic [5:0] F0  = 6'b000010;
  localparam logic [5:0] F1  = 6'b000001;

  typedef struct packed {
    logic       rst;
    logic       i0;
    logic       i1;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  logic in0;
  logic in1;
  logic out0;
  logic out1;
  logic rise0;
  logic rise1;
  logic fall0;
  logic fall1;

  int n_checks;
  int n_fail;
  vec_t vecs[$];

  fpga_input_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (24)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in0  (in0),
    .in1  (in1),
    .out0 (out0),
    .out1 (out1),
    .rise0(rise0),
    .rise1(rise1),
    .fall0(fall0),
    .fall1(fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic addn(input int n, input logic r, input logic i0, input logic i1,
                      input logic [5:0] e);
    for (int k = 0; k < n; k++) vecs.push_back({r, i0, i1, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] bounce;
    logic [5:0] act;
    int         lat;
    bit         found;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in0      = 1'b1;
    in1      = 1'b1;

    // Reset held 3 cycles with both pads high, then release and qualify.
    addn(3, 1, 1, 1, O00);
    addn(5, 0, 1, 1, O00);
    addn(1, 0, 1, 1, O11 | R0 | R1);
    addn(1, 0, 1, 1, O11);
    // 3-cycle low glitch on in1 is rejected.
    addn(3, 0, 1, 0, O11);
    addn(4, 0, 1, 1, O11);
    // Clean release then clean press on in0.
    addn(5, 0, 0, 1, O11);
    addn(1, 0, 0, 1, O01 | F0);
    addn(1, 0, 0, 1, O01);
    addn(5, 0, 1, 1, O01);
    addn(1, 0, 1, 1, O11 | R0);
    addn(1, 0, 1, 1, O11);
    addn(5, 0, 0, 1, O11);
    addn(1, 0, 0, 1, O01 | F0);
    addn(3, 0, 0, 1, O01);
    // Bounce 1,0,1,1,0,1,1,1,1,1: only the final run qualifies.
    bounce = 10'b1011011111;
    for (int k = 9; k >= 0; k--) addn(1, 0, bounce[k], 1, O01);
    addn(1, 0, 1, 1, O11 | R0);
    addn(1, 0, 1, 1, O11);
    // Opposite-direction changes on the same edge.
    addn(5, 0, 0, 1, O11);
    addn(1, 0, 0, 1, O01 | F0);
    addn(1, 0, 0, 1, O01);
    addn(5, 0, 1, 0, O01);
    addn(1, 0, 1, 0, O10 | R0 | F1);
    addn(1, 0, 1, 0, O10);
    // Reset after two qualifying samples, then full requalification.
    addn(5, 0, 0, 0, O10);
    addn(1, 0, 0, 0, O00 | F0);
    addn(1, 0, 0, 0, O00);
    addn(4, 0, 1, 0, O00);
    addn(1, 1, 1, 0, O00);
    addn(5, 0, 1, 0, O00);
    addn(1, 0, 1, 0, O10 | R0);
    addn(1, 0, 1, 0, O10);
    // Reset while stable high: out0 drops with no fall pulse.
    addn(1, 1, 1, 0, O00);
    addn(5, 0, 1, 0, O00);
    addn(1, 0, 1, 0, O10 | R0);
    addn(1, 0, 1, 0, O10);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      in0 = vecs[i].i0;
      in1 = vecs[i].i1;
      tick();
      act = {out0, out1, rise0, rise1, fall0, fall1};
      chk($sformatf("vec%0d_outputs", i), 8'(act), 8'(vecs[i].exp));
      chk($sformatf("vec%0d_and", i), 8'(out0 & out1), 8'(vecs[i].exp[5] & vecs[i].exp[4]));
      chk($sformatf("vec%0d_excl", i), 8'((rise0 & fall0) | (rise1 & fall1)), 8'(0));
    end

    // Bounded wait for rise1 after a press; latency counted from the sampling edge.
    in1   = 1'b1;
    found = 1'b0;
    lat   = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (rise1) begin
        found = 1'b1;
        lat   = k;
      end
    end
    chk("rise1_seen", 8'(found), 8'(1));
    chk("rise1_latency", 8'(lat), 8'(STABLE + 1));
    chk("rise1_with_out1", 8'({out1, rise1, fall1}), 8'(3'b110));
    tick();
    chk("rise1_one_cycle", 8'({out1, rise1}), 8'(2'b10));
    chk("and_both_high", 8'(out0 & out1), 8'(1));

    // Bounded wait for fall1 after release; out0 must be unaffected.
    in1   = 1'b0;
    found = 1'b0;
    lat   = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (fall1) begin
        found = 1'b1;
        lat   = k;
      end
    end
    chk("fall1_seen", 8'(found), 8'(1));
    chk("fall1_latency", 8'(lat), 8'(STABLE + 1));
    chk("fall1_state", 8'({out0, out1, rise0, rise1, fall0, fall1}), 8'(O10 | F1));
    tick();
    chk("fall1_one_cycle", 8'({out0, out1, fall1}), 8'(3'b100));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
